// File: rtl/perf_counter_ctrl.sv
// CSR front end for the performance counter array: decodes CSR accesses, holds event
// selectors and the inhibit mask, and drives per-counter increment/write/read paths.
module perf_counter_ctrl #(
  parameter int unsigned NumCounters  = 2,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned CounterWidth = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        csr_req_i,
  input  logic                        csr_we_i,
  input  logic [7:0]                  csr_addr_i,
  input  logic [31:0]                 csr_wdata_i,
  output logic                        csr_gnt_o,
  output logic                        csr_rvalid_o,
  output logic [31:0]                 csr_rdata_o,
  output logic                        csr_err_o,
  input  logic [NumEvents-1:0]        event_i,
  output logic [NumCounters-1:0]      counter_inc_o,
  output logic [NumCounters-1:0]      counter_we_o,
  output logic [NumCounters-1:0]      counterh_we_o,
  output logic [32*NumCounters-1:0]   counter_wdata_o,
  input  logic [64*NumCounters-1:0]   counter_val_i
);

  localparam logic [2:0] RegionCtrl  = 3'd0;
  localparam logic [2:0] RegionEvsel = 3'd1;
  localparam logic [2:0] RegionCntLo = 3'd2;
  localparam logic [2:0] RegionCntHi = 3'd3;

  // Counter width only matters downstream; reads pass the 64-bit value through.
  localparam int unsigned unused_counter_width = CounterWidth;

  logic [2:0]  w_region;
  logic [4:0]  w_idx;
  logic        w_idx_ok;
  logic        w_hit_inhibit;
  logic        w_hit_evsel;
  logic        w_hit_lo;
  logic        w_hit_hi;
  logic        w_err;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_rdata;
  logic        w_unused_wdata;

  logic [NumCounters-1:0] r_inhibit;
  logic [NumEvents-1:0]   r_evsel [NumCounters];
  logic [NumEvents-1:0]   r_event_q;
  logic                   r_rvalid;
  logic [31:0]            r_rdata;
  logic                   r_err;

  // Address decode
  assign w_region      = csr_addr_i[7:5];
  assign w_idx         = csr_addr_i[4:0];
  assign w_idx_ok      = ({27'd0, w_idx} < NumCounters);
  assign w_hit_inhibit = (w_region == RegionCtrl) && (w_idx == 5'd0);
  assign w_hit_evsel   = (w_region == RegionEvsel) && w_idx_ok;
  assign w_hit_lo      = (w_region == RegionCntLo) && w_idx_ok;
  assign w_hit_hi      = (w_region == RegionCntHi) && w_idx_ok;
  assign w_err         = ~(w_hit_inhibit | w_hit_evsel | w_hit_lo | w_hit_hi);
  assign w_wr          = csr_req_i & csr_we_i;
  assign w_rd          = csr_req_i & ~csr_we_i;

  // Write data wider than the implemented registers is simply dropped.
  assign w_unused_wdata = ^csr_wdata_i;

  assign csr_gnt_o = csr_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inhibit <= '1;
    end else if (w_wr && w_hit_inhibit) begin
      r_inhibit <= csr_wdata_i[NumCounters-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_event_q <= '0;
    end else begin
      r_event_q <= event_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumCounters; gi++) begin : g_counter
      logic w_sel;
      assign w_sel = (w_idx == 5'(gi));

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_evsel[gi] <= '0;
        end else if (w_wr && w_hit_evsel && w_sel) begin
          r_evsel[gi] <= csr_wdata_i[NumEvents-1:0];
        end
      end

      assign counter_we_o[gi]  = w_wr & w_hit_lo & w_sel;
      assign counterh_we_o[gi] = w_wr & w_hit_hi & w_sel;
      assign counter_wdata_o[32*gi +: 32] =
          (counter_we_o[gi] | counterh_we_o[gi]) ? csr_wdata_i : 32'd0;

      // A direct counter write in the same cycle takes priority over counting.
      assign counter_inc_o[gi] = (|(r_event_q & r_evsel[gi])) & ~r_inhibit[gi] &
                                 ~counter_we_o[gi] & ~counterh_we_o[gi];
    end
  endgenerate

  always_comb begin
    w_rdata = 32'd0;
    if (w_hit_inhibit) begin
      w_rdata = 32'(r_inhibit);
    end
    for (int k = 0; k < NumCounters; k++) begin
      if (w_idx == 5'(k)) begin
        if (w_hit_evsel) w_rdata = 32'(r_evsel[k]);
        if (w_hit_lo)    w_rdata = counter_val_i[64*k +: 32];
        if (w_hit_hi)    w_rdata = counter_val_i[64*k+32 +: 32];
      end
    end
  end

  // Response stage: data is captured at grant and held zero when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= csr_req_i;
      r_rdata  <= (w_rd && !w_err) ? w_rdata : 32'd0;
      r_err    <= csr_req_i & w_err;
    end
  end

  assign csr_rvalid_o = r_rvalid;
  assign csr_rdata_o  = r_rdata;
  assign csr_err_o    = r_err;

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Randomized bench for perf_counter_ctrl against an address-map level reference model.
module tb_perf_counter_ctrl;
  localparam int NC = 2;
  localparam int NE = 16;

  logic              clk_i = 0;
  logic              rst_ni;
  logic              csr_req_i;
  logic              csr_we_i;
  logic [7:0]        csr_addr_i;
  logic [31:0]       csr_wdata_i;
  logic              csr_gnt_o;
  logic              csr_rvalid_o;
  logic [31:0]       csr_rdata_o;
  logic              csr_err_o;
  logic [NE-1:0]     event_i;
  logic [NC-1:0]     counter_inc_o;
  logic [NC-1:0]     counter_we_o;
  logic [NC-1:0]     counterh_we_o;
  logic [32*NC-1:0]  counter_wdata_o;
  logic [64*NC-1:0]  counter_val_i;

  perf_counter_ctrl #(.NumCounters(NC), .NumEvents(NE), .CounterWidth(10)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .csr_req_i(csr_req_i), .csr_we_i(csr_we_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_gnt_o(csr_gnt_o),
    .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o), .csr_err_o(csr_err_o),
    .event_i(event_i), .counter_inc_o(counter_inc_o), .counter_we_o(counter_we_o),
    .counterh_we_o(counterh_we_o), .counter_wdata_o(counter_wdata_o),
    .counter_val_i(counter_val_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int unsigned m_inh;
  int unsigned m_evsel [NC];
  int unsigned m_evq;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_inh = (1 << NC) - 1;
    for (int i = 0; i < NC; i++) m_evsel[i] = 0;
    m_evq = 0;
  endtask

  // One bus cycle: drive, check combinational outputs, clock, check response.
  task automatic cyc(input bit req, input bit we, input logic [7:0] addr,
                     input logic [31:0] wd, input logic [NE-1:0] ev,
                     input logic [64*NC-1:0] val);
    int region, idx;
    bit ok;
    logic [63:0] exp_we, exp_weh, exp_wdata, exp_inc;
    logic [64*NC-1:0] shifted;
    logic [31:0] exp_rdata;
    bit exp_err;
    @(negedge clk_i);
    csr_req_i = req; csr_we_i = we; csr_addr_i = addr; csr_wdata_i = wd;
    event_i = ev; counter_val_i = val;
    #1;
    region = int'(addr) / 32;
    idx    = int'(addr) % 32;
    ok = (region == 0 && idx == 0) || (region >= 1 && region <= 3 && idx < NC);
    exp_we    = (req && we && ok && region == 2) ? (64'd1 << idx) : 64'd0;
    exp_weh   = (req && we && ok && region == 3) ? (64'd1 << idx) : 64'd0;
    exp_wdata = (exp_we != 0 || exp_weh != 0) ? (64'(wd) << (32 * idx)) : 64'd0;
    exp_inc = 0;
    for (int i = 0; i < NC; i++)
      if ((m_evq & m_evsel[i]) != 0 && ((m_inh >> i) & 1) == 0 && !exp_we[i] && !exp_weh[i])
        exp_inc[i] = 1'b1;
    check_eq("gnt", 64'(csr_gnt_o), 64'(req));
    check_eq("we", 64'(counter_we_o), exp_we);
    check_eq("weh", 64'(counterh_we_o), exp_weh);
    check_eq("wdata", 64'(counter_wdata_o), exp_wdata);
    check_eq("inc", 64'(counter_inc_o), exp_inc);
    exp_rdata = 0;
    if (req && !we && ok) begin
      shifted = val >> (64 * idx);
      case (region)
        0: exp_rdata = m_inh;
        1: exp_rdata = m_evsel[idx];
        2: exp_rdata = shifted[31:0];
        default: exp_rdata = shifted[63:32];
      endcase
    end
    exp_err = req && !ok;
    @(posedge clk_i);
    m_evq = ev;
    if (req && we && ok && region == 0) m_inh = wd & ((1 << NC) - 1);
    if (req && we && ok && region == 1) m_evsel[idx] = wd & ((1 << NE) - 1);
    #1;
    check_eq("rvalid", 64'(csr_rvalid_o), 64'(req));
    check_eq("rdata", 64'(csr_rdata_o), 64'(exp_rdata));
    check_eq("err", 64'(csr_err_o), 64'(exp_err));
    $display("[TB] req=%0b we=%0b addr=0x%02h wd=0x%08h ev=0x%04h -> rdata=0x%08h err=%0b inc=%b",
             req, we, addr, wd, ev, csr_rdata_o, csr_err_o, counter_inc_o);
  endtask

  logic [64*NC-1:0] vals;
  logic [7:0] a;

  initial begin
    rst_ni = 0; csr_req_i = 0; csr_we_i = 0; csr_addr_i = 0; csr_wdata_i = 0;
    event_i = '1; counter_val_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_rvalid", 64'(csr_rvalid_o), 0);
    check_eq("rst_rdata", 64'(csr_rdata_o), 0);
    check_eq("rst_inc", 64'(counter_inc_o), 0);
    @(negedge clk_i);
    rst_ni = 1; event_i = 0;

    vals = {64'h0, 64'h0000_0123_0000_0456};
    cyc(1, 0, 8'h00, 0, 0, vals);
    check_eq("inh_reset_val", 64'(csr_rdata_o), 64'h3);
    cyc(1, 0, 8'h20, 0, 0, vals);
    cyc(1, 1, 8'h00, 0, 0, vals);
    cyc(1, 1, 8'h20, 32'h0004, 0, vals);
    cyc(0, 0, 8'h00, 0, 16'h0004, vals);
    cyc(0, 0, 8'h00, 0, 16'h0000, vals);
    check_eq("no_inc_after_pulse", 64'(counter_inc_o), 0);
    cyc(0, 0, 8'h00, 0, 16'h0008, vals);
    cyc(1, 1, 8'h41, 32'hDEADBEEF, 0, vals);
    cyc(1, 1, 8'h61, 32'h12345678, 0, vals);
    cyc(1, 0, 8'h40, 0, 0, vals);
    check_eq("rd_lo", 64'(csr_rdata_o), 64'h456);
    cyc(1, 0, 8'h60, 0, 0, vals);
    check_eq("rd_hi", 64'(csr_rdata_o), 64'h123);
    cyc(0, 0, 8'h00, 0, 16'h0004, vals);
    cyc(1, 1, 8'h40, 32'h1, 0, vals);
    cyc(1, 1, 8'h00, 32'h1, 16'h0004, vals);
    cyc(0, 0, 8'h00, 0, 16'h0004, vals);
    cyc(0, 0, 8'h00, 0, 0, vals);
    cyc(1, 1, 8'h22, 32'hFFFF, 0, vals);
    cyc(1, 0, 8'h22, 0, 0, vals);
    cyc(1, 1, 8'h10, 32'hFFFF, 0, vals);
    cyc(1, 0, 8'h00, 0, 0, vals);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: a = 8'h00;
        1: a = 8'h20 + 8'($urandom_range(0, 2));
        2: a = 8'h40 + 8'($urandom_range(0, 2));
        3: a = 8'h60 + 8'($urandom_range(0, 2));
        default: a = 8'($urandom);
      endcase
      vals = {$urandom, $urandom, $urandom, $urandom};
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
          (a == 8'h00) ? 32'($urandom_range(0, 7)) : $urandom,
          NE'($urandom & $urandom & $urandom), vals);
    end

    // Reset in the middle of a read with events pending
    cyc(1, 1, 8'h00, 0, 0, vals);
    cyc(1, 1, 8'h20, 32'hFFFF, 16'hFFFF, vals);
    @(negedge clk_i);
    csr_req_i = 1; csr_we_i = 0; csr_addr_i = 8'h00; event_i = 16'hFFFF;
    #1 rst_ni = 0;
    #1 check_eq("midrst_inc_async", 64'(counter_inc_o), 0);
    check_eq("midrst_rvalid_async", 64'(csr_rvalid_o), 0);
    @(posedge clk_i);
    #1;
    check_eq("midrst_rvalid", 64'(csr_rvalid_o), 0);
    check_eq("midrst_inc", 64'(counter_inc_o), 0);
    @(negedge clk_i);
    rst_ni = 1; csr_req_i = 0; event_i = 0;
    model_reset();
    cyc(1, 0, 8'h00, 0, 16'hFFFF, vals);
    check_eq("inh_after_rst", 64'(csr_rdata_o), 64'h3);
    cyc(1, 0, 8'h20, 0, 0, vals);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/perf_counter_ctrl.md
Name: perf_counter_ctrl

Overview:
CSR-facing control stage that sits directly upstream of the array of performance counter instances. Decodes CSR read/write requests and registers per-counter event selectors and an inhibit mask. Drives each counter's increment, low/high write-enable and write-data inputs, and returns counter values on CSR reads.

Parameters:
NumCounters, 2, number of downstream counter instances (1..16)
NumEvents, 16, width of the raw event bus (1..32)
CounterWidth, 10, implemented counter width; informational only, reads pass counter_val_i through unchanged

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
csr_req_i  input  1  CSR access request
csr_we_i  input  1  1 = write, 0 = read
csr_addr_i  input  8  CSR address (map below)
csr_wdata_i  input  32  CSR write data
csr_gnt_o  output  1  request accepted
csr_rvalid_o  output  1  response valid, one cycle after grant
csr_rdata_o  output  32  read data, valid with csr_rvalid_o
csr_err_o  output  1  access error, valid with csr_rvalid_o
event_i  input  NumEvents  raw single-cycle event pulses
counter_inc_o  output  NumCounters  per-counter increment
counter_we_o  output  NumCounters  per-counter low-word write enable
counterh_we_o  output  NumCounters  per-counter high-word write enable
counter_wdata_o  output  32*NumCounters  per-counter write data, slice i = [32i+31:32i]
counter_val_i  input  64*NumCounters  per-counter current value, slice i = [64i+63:64i]

Behaviour:
- Reset is asynchronous and active-low on rst_ni; clock is clk_i.
- Address map (i = addr[4:0]):
  - 0x00 = inhibit mask, bit i for counter i.
  - 0x20+i = event select i.
  - 0x40+i = counter i low word.
  - 0x60+i = counter i high word.
- Any other address, or i >= NumCounters, is an error access: no side effect, rdata 0, err 1.
- Handshake:
  - csr_gnt_o = csr_req_i (combinational); every request is accepted.
  - The response is registered: csr_rvalid_o is high exactly one cycle after each granted request.
  - csr_rdata_o and csr_err_o are valid only while csr_rvalid_o is high, otherwise 0.
  - Back-to-back requests give back-to-back responses.
  - Writes also produce a response, with rdata 0.
- Registers:
  - inhibit: NumCounters bits, reset all ones (counters stopped).
  - evsel[i]: NumEvents bits, reset 0.
  - Write bits beyond the implemented width are ignored; those bits read as 0.
- Counter writes (same cycle as grant, combinational):
  - A write to 0x40+i drives counter_we_o[i] = 1 with slice i of counter_wdata_o = csr_wdata_i.
  - A write to 0x60+i does the same on counterh_we_o[i].
  - Otherwise enables are 0 and counter_wdata_o is 0.
- Counter reads: rdata is sampled at grant from counter_val_i slice i, bits [31:0] or [63:32], and registered into csr_rdata_o.
- Event path (1-cycle pipeline):
  - event_q <= event_i every cycle; reset 0.
  - counter_inc_o[i] = |(event_q & evsel[i]) & ~inhibit[i] & ~counter_we_o[i] & ~counterh_we_o[i].
  - Multiple selected events in one cycle give a single increment.
- Simultaneous events:
  - A counter write in the same cycle suppresses that counter's increment (the write wins).
  - A write to inhibit or evsel takes effect from the next cycle; the increment in the write cycle uses the old register value.
- Reset mid-operation:
  - All registers return to reset values immediately; event_q is cleared.
  - Any pending response is dropped: csr_rvalid_o = 0.
  - counter_inc_o = 0 while rst_ni is low.
- Outputs at reset: csr_rvalid_o 0, csr_rdata_o 0, csr_err_o 0, counter_inc_o 0.
  - csr_gnt_o follows csr_req_i.
  - Write enables are 0 unless a write is requested.

Test Plan:
- Reset, then read 0x00 -> rvalid next cycle with rdata 0x3; read 0x20 -> rdata 0x0000, err 0.
- Write 0x00 = 0, 0x20 = 0x0004; pulse event_i = 0x0004 at cycle T -> counter_inc_o = 2'b01 at T+1 only; event_i = 0x0008 -> no increment.
- Write 0x41 = 0xDEADBEEF -> counter_we_o = 2'b10 and counter_wdata_o[63:32] = 0xDEADBEEF in the grant cycle; write 0x61 -> counterh_we_o = 2'b10.
- With counter_val_i = 0x...0000_0123_0000_0456 (slice 0), read 0x40 -> rdata 0x00000456; read 0x60 -> rdata 0x00000123.
- Event selected for counter 0 coinciding with a write to 0x40 -> counter_inc_o[0] = 0 and counter_we_o[0] = 1; set inhibit bit 0 -> subsequent events give no increment.
- Access 0x22 (NumCounters = 2) and 0x10 -> err 1, rdata 0, no state change; assert rst_ni low during a read -> rvalid stays 0 and inhibit returns to 0x3.
